// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order alloc/commit, out-of-order CDB capture.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB results to lookups.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int NCDB   = 6,
  parameter int AREG_W = 5,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [AREG_W-1:0]      alloc_rd,
  input  logic                   alloc_wen,
  output logic                   alloc_ready,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*XLEN-1:0]   cdb_data,
  input  logic [TAG_W-1:0]       lk0_tag,
  input  logic [TAG_W-1:0]       lk1_tag,
  output logic                   lk0_ready,
  output logic                   lk1_ready,
  output logic [XLEN-1:0]        lk0_data,
  output logic [XLEN-1:0]        lk1_data,
  output logic                   commit_valid,
  output logic                   commit_wen,
  output logic [AREG_W-1:0]      commit_idx,
  output logic [XLEN-1:0]        commit_data,
  input  logic                   flush,
  output logic [TAG_W:0]         count,
  output logic                   empty
);

  localparam logic [TAG_W:0]   FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] ONE  = TAG_W'(1);

  logic              r_valid [DEPTH];
  logic              r_done  [DEPTH];
  logic              r_wen   [DEPTH];
  logic [AREG_W-1:0] r_rd    [DEPTH];
  logic [XLEN-1:0]   r_data  [DEPTH];

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic              r_cvalid;
  logic              r_cwen;
  logic [AREG_W-1:0] r_cidx;
  logic [XLEN-1:0]   r_cdata;

  logic              w_cap      [DEPTH];
  logic [XLEN-1:0]   w_cap_data [DEPTH];
  logic              w_alloc_fire;
  logic              w_commit_fire;

  logic [TAG_W-1:0]  w_lk_tag [2];
  logic              w_lk_rdy [2];
  logic [XLEN-1:0]   w_lk_dat [2];

  assign alloc_ready   = (r_count != FULL);
  assign alloc_tag     = r_tail;
  assign w_alloc_fire  = alloc_valid & alloc_ready;
  assign w_commit_fire = r_valid[r_head] & r_done[r_head];
  assign count         = r_count;
  assign empty         = (r_count == '0);
  assign commit_valid  = r_cvalid;
  assign commit_wen    = r_cwen;
  assign commit_idx    = r_cidx;
  assign commit_data   = r_cdata;

  // Per-entry CDB hit; descending scan lets the lowest channel win
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_cap[e]      = 1'b0;
      w_cap_data[e] = '0;
      for (int i = NCDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] &&
            cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e) &&
            r_valid[e] && !r_done[e]) begin
          w_cap[e]      = 1'b1;
          w_cap_data[e] = cdb_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign w_lk_tag[0] = lk0_tag;
  assign w_lk_tag[1] = lk1_tag;
  assign lk0_ready   = w_lk_rdy[0];
  assign lk1_ready   = w_lk_rdy[1];
  assign lk0_data    = w_lk_dat[0];
  assign lk1_data    = w_lk_dat[1];

  // Rename lookups: stored done value, optionally same-cycle CDB
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_lk_rdy[k] = 1'b0;
      w_lk_dat[k] = '0;
      if (r_valid[w_lk_tag[k]] && r_done[w_lk_tag[k]]) begin
        w_lk_rdy[k] = 1'b1;
        w_lk_dat[k] = r_data[w_lk_tag[k]];
      end
`ifdef ROB_CDB_BYPASS_EN
      else if (w_cap[w_lk_tag[k]]) begin
        w_lk_rdy[k] = 1'b1;
        w_lk_dat[k] = w_cap_data[w_lk_tag[k]];
      end
`endif
    end
  end

  // Entry state: capture, retire and allocate; flush drops everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_valid[e] <= 1'b0;
        r_done[e]  <= 1'b0;
        r_wen[e]   <= 1'b0;
        r_rd[e]    <= '0;
        r_data[e]  <= '0;
      end
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_valid[e] <= 1'b0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_cap[e]) begin
          r_done[e] <= 1'b1;
          r_data[e] <= w_cap_data[e];
        end
      end
      if (w_commit_fire) begin
        r_valid[r_head] <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_wen[r_tail]   <= alloc_wen;
        r_rd[r_tail]    <= alloc_rd;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit_fire) r_head <= r_head + ONE;
      if (w_alloc_fire)  r_tail <= r_tail + ONE;
      unique case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered commit bus toward the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cvalid <= 1'b0;
      r_cwen   <= 1'b0;
      r_cidx   <= '0;
      r_cdata  <= '0;
    end else if (flush) begin
      r_cvalid <= 1'b0;
      r_cwen   <= 1'b0;
    end else begin
      r_cvalid <= w_commit_fire;
      r_cwen   <= w_commit_fire & r_wen[r_head];
      if (w_commit_fire) begin
        r_cidx  <= r_rd[r_head];
        r_cdata <= r_data[r_head];
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised circular reorder buffer for the Tomasulo core. It allocates one entry per issued instruction in program order and captures results from `NCDB` common-data-bus channels. It exposes completed-but-uncommitted values to the rename logic through two lookup ports, and retires one entry per cycle in order onto the register-file commit bus. It replaces the fixed-size ROB inside the order manager with depth, width and CDB channel count set by parameters, and adds flush.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `XLEN`, 32: data width.
- `NCDB`, 6: number of CDB channels (ADD1-3, MUL1-2, LS).
- `AREG_W`, 5: architectural register index width.
- `TAG_W`, $clog2(DEPTH): entry tag width; derived, not overridden.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `alloc_valid` in 1: allocate one entry this cycle.
- `alloc_rd` in AREG_W: destination register of the allocated entry.
- `alloc_wen` in 1: entry writes the register file on commit.
- `alloc_ready` out 1: combinational, `count < DEPTH`.
- `alloc_tag` out TAG_W: tail pointer; tag given to the entry allocated this cycle.
- `cdb_valid` in NCDB: per-channel result strobe.
- `cdb_tag` in NCDB*TAG_W: per-channel tag, channel i at bits [i*TAG_W +: TAG_W].
- `cdb_data` in NCDB*XLEN: per-channel result, packed the same way.
- `lk0_tag`, `lk1_tag` in TAG_W: lookup tags (Qj, Qk).
- `lk0_ready`, `lk1_ready` out 1: the looked-up entry is valid and done.
- `lk0_data`, `lk1_data` out XLEN: the looked-up value; 0 when not ready.
- `commit_valid` out 1: registered; one entry retired.
- `commit_wen` out 1: registered; `commit_valid & entry.wen`.
- `commit_idx` out AREG_W: registered destination register.
- `commit_data` out XLEN: registered result.
- `flush` in 1: synchronous discard of all entries.
- `count` out TAG_W+1: occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Each entry holds `valid`, `done`, `wen`, `rd` and `data`.
- Pointers: `head` (oldest) and `tail` (next free), both TAG_W bits wide. They wrap modulo DEPTH naturally.
- **Alloc:** when `alloc_valid & alloc_ready`, the entry at `tail` gets `valid=1`, `done=0`, and `rd`/`wen` latched; then `tail++`. When `alloc_valid` is high and `alloc_ready` is low, the request is dropped and no state changes. The upstream stalls using `alloc_ready`.
- **CDB capture:** for each channel with `cdb_valid[i]` whose tag hits an entry with `valid & ~done`, latch the data and set `done`.
  - Writes to invalid or already-done entries are ignored.
  - If two channels carry the same tag in one cycle, the lowest channel index wins.
- **Commit:** when the `head` entry is `valid & done`, register its `rd`/`data`/`wen` onto the commit outputs, clear `valid`, and `head++`. Otherwise `commit_valid=0` next cycle. Maximum one commit per cycle.
- Entries with `wen=0` (stores) still need a CDB completion. They commit with `commit_wen=0`.
- **`count` update:** `count += alloc_fire - commit_fire`.
- **Full and empty:**
  - `alloc_ready` does not account for a commit in the same cycle, so a full buffer accepts again the cycle after a commit.
  - When empty, no commit occurs.
- **Same-slot alloc and CDB:** a CDB hit on the slot being allocated in the same cycle is ignored, because the slot is invalid. The allocation wins.
- **Flush:** has priority over alloc, CDB and commit. It clears every `valid`, sets `head=tail=count=0`, and drives `commit_valid`/`commit_wen` to 0 next cycle.

## Timing
- **Reset values:**
  - Commit outputs: `commit_valid=0`, `commit_wen=0`, `commit_idx=0`, `commit_data=0`.
  - Occupancy: `count=0`, `empty=1`.
  - Allocation: `alloc_ready=1`, `alloc_tag=0`.
  - Lookup: `lk*_ready=0`, `lk*_data=0`.
  - All entries invalid.
  - Reset asserted mid-operation discards everything immediately, with no commit.
- **Latency:**
  - Alloc at edge N.
  - Earliest CDB capture at edge N+1.
  - Commit registered at edge N+2; `commit_valid` is high during cycle N+2.
- **Lookup** is combinational from the `lk*_tag` inputs and entry state. A value captured at edge N is visible from cycle N onward.
- **Commit throughput:** a contiguous run of done entries commits one per cycle.

## Configuration
- `ROB_CDB_BYPASS_EN`, defined:
  - A lookup also matches the same-cycle CDB, using the same lowest-index priority, and returns `ready=1` with the CDB data.
  - This lets a dispatching instruction capture a result broadcast in its own issue cycle.
  - It adds one combinational path from `cdb_*` to `lk*_*`.
- Undefined: lookups reflect stored entry state only. The CDB result becomes visible one cycle later.

## Test plan
- **Basic retire:** reset, alloc rd=3 wen=1 (tag 0), CDB ch2 tag0 data 0xDEAD_BEEF → next-next cycle `commit_valid=1`, `commit_idx=3`, `commit_data=0xDEADBEEF`, `count` back to 0.
- **Out-of-order completion:** alloc tags 0,1,2; CDB completes 2, then 1, then 0 → commits in order 0,1,2 on three consecutive cycles after tag 0 completes.
- **Full:** alloc 8 entries with DEPTH=8 → `alloc_ready=0`, `count=8`, and a 9th `alloc_valid` is ignored. Complete tag 0 → one commit, then `alloc_ready=1`, next `alloc_tag=0` (wrap).
- **CDB collision:** ch0 and ch4 both carry tag 1, data 0x11/0x44 → entry 1 holds 0x11. Later ch3 tag 1 data 0x33 is ignored.
- **Flush:** 5 entries live, 2 done, flush → next cycle `count=0`, `empty=1`, no commit. A subsequent alloc gets tag 0.
- **Bypass:** `lk0_tag=2` with CDB ch1 tag 2 data 0x55 in the same cycle → `lk0_ready=1`, `lk0_data=0x55` with `ROB_CDB_BYPASS_EN` defined. Without it, `lk0_ready=0` that cycle and 1 the next.
